// File: rtl/inv_add_round_key_stage_pkg.sv
// Shared AES decryption datapath constants and payload types.
package inv_add_round_key_stage_pkg;

   localparam int AES_NR      = 10;   // AES-128 round count; round keys 0..AES_NR
   localparam int AES_STATE_W = 128;  // one AES state, byte 0 in the top byte
   localparam int AES_RIDX_W  = 4;    // round index width, 2**AES_RIDX_W > AES_NR

   typedef logic [AES_STATE_W-1:0] state_t;
   typedef logic [AES_RIDX_W-1:0]  ridx_t;

endpackage

// File: rtl/inv_add_round_key_stage_skid_buf.sv
// Generic 2-entry valid/ready skid buffer.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; valid never depends on ready, and in_ready is a flop (it is !B_full of
// the next cycle), so nothing combinational runs from out_ready to in_ready.
// Entry A drives the output; entry B catches the one state that can arrive
// in the cycle in which A stalls.
module aes_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         a_valid_q, a_valid_d;
   logic         b_valid_q, b_valid_d;
   logic [W-1:0] a_data_q,  a_data_d;
   logic [W-1:0] b_data_q,  b_data_d;
   logic         in_ready_q, in_ready_d;
   logic         push;
   logic         pop;

   assign push      = in_valid & in_ready_q;
   assign pop       = a_valid_q & out_ready;
   assign in_ready  = in_ready_q;
   assign out_valid = a_valid_q;
   assign out_data  = a_data_q;

   // Next-state of both entries: clear wins, B moves to A before a new push lands.
   always_comb begin
      a_valid_d = a_valid_q;
      b_valid_d = b_valid_q;
      a_data_d  = a_data_q;
      b_data_d  = b_data_q;
      if (clear) begin
         a_valid_d = 1'b0;
         b_valid_d = 1'b0;
      end else if (pop) begin
         if (b_valid_q) begin
            a_valid_d = 1'b1;
            a_data_d  = b_data_q;
            b_valid_d = push;
            if (push) b_data_d = in_data;
         end else begin
            a_valid_d = push;
            if (push) a_data_d = in_data;
         end
      end else if (push) begin
         if (!a_valid_q) begin
            a_valid_d = 1'b1;
            a_data_d  = in_data;
         end else begin
            b_valid_d = 1'b1;
            b_data_d  = in_data;
         end
      end
      in_ready_d = !b_valid_d;
   end

   // Entry and ready registers; ready stays low while reset is held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_valid_q  <= 1'b0;
         b_valid_q  <= 1'b0;
         a_data_q   <= '0;
         b_data_q   <= '0;
         in_ready_q <= 1'b0;
      end else begin
         a_valid_q  <= a_valid_d;
         b_valid_q  <= b_valid_d;
         a_data_q   <= a_data_d;
         b_data_q   <= b_data_d;
         in_ready_q <= in_ready_d;
      end
   end

endmodule

// File: rtl/inv_add_round_key_stage.sv
// Registered AddRoundKey stage of the AES-128 decryption datapath.
// XORs each incoming state with the round key selected by the inverse round
// counter, tags round 0 as the last (plaintext) output, and buffers the result
// in a 2-entry skid buffer so one state per clock can flow.
module inv_add_round_key_stage
   import inv_add_round_key_stage_pkg::*;
#(
   parameter int NR     = AES_NR,
   parameter int RIDX_W = AES_RIDX_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  state_t            in_state,
   output logic [RIDX_W-1:0] rk_idx,
   input  state_t            rk_data,
   output logic              out_valid,
   input  logic              out_ready,
   output state_t            out_state,
   output logic [RIDX_W-1:0] out_round,
   output logic              out_last
);

   // Highest round this stage performs; key NR is the initial AddRoundKey, done elsewhere.
   localparam logic [RIDX_W-1:0] RND_TOP = RIDX_W'(NR - 1);
   localparam int                PW      = AES_STATE_W + RIDX_W + 1;

   logic [RIDX_W-1:0] cnt_q, cnt_d;
   logic              accept;
   logic [PW-1:0]     in_pl;
   logic [PW-1:0]     out_pl;

   assign accept = in_valid & in_ready;
   assign rk_idx = cnt_q;
   assign in_pl  = {in_state ^ rk_data, cnt_q, cnt_q == '0};
   assign {out_state, out_round, out_last} = out_pl;

   // Round counter: counts down per accept, explicit wrap 0 -> NR-1, clear restarts.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = RND_TOP;
      end else if (accept) begin
         cnt_d = (cnt_q == '0) ? RND_TOP : cnt_q - RIDX_W'(1);
      end
   end

   // Round counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= RND_TOP;
      else       cnt_q <= cnt_d;
   end

   aes_skid_buf #(
      .W (PW)
   ) u_skid (
      .clk       (clk),
      .rst       (reset),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_pl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_pl)
   );

endmodule

// File: tb/tb_inv_add_round_key_stage.sv
// Bench for inv_add_round_key_stage: directed cases plus a random stall run
// against a queue-based reference of in_state ^ key[round].
module tb_inv_add_round_key_stage;

   localparam int NR = 10;
   typedef logic [132:0] chk_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         clear;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic [3:0]   rk_idx;
   logic [127:0] rk_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;
   logic [3:0]   out_round;
   logic         out_last;

   logic [127:0] key_mem [0:15];
   logic [132:0] exp_q [$];
   int           n_checks = 0;
   int           n_fail   = 0;
   int           acc_k    = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // Key store model: combinational lookup of the requested round key.
   assign rk_data = key_mem[rk_idx];

   inv_add_round_key_stage dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .rk_idx    (rk_idx),
      .rk_data   (rk_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .out_round (out_round),
      .out_last  (out_last)
   );

   // ---------------- checking ----------------
   task automatic check(input string tag, input chk_t act, input chk_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- scoreboard / monitor ----------------
   // The k-th accept since reset/clear uses round NR-1 - (k mod NR).
   logic         prev_hold = 1'b0;
   logic [132:0] prev_out  = '0;
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         acc_k     = 0;
         prev_hold = 1'b0;
      end else begin
         if (prev_hold)
            check("hold", chk_t'({out_state, out_round, out_last}), chk_t'(prev_out));
         if (clear) begin
            exp_q.delete();
            acc_k = 0;
         end else begin
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) check("sb_underflow", chk_t'(1), chk_t'(0));
               else check("sb", chk_t'({out_state, out_round, out_last}), chk_t'(exp_q.pop_front()));
            end
            if (in_valid && in_ready) begin
               int rnd;
               rnd = NR - 1 - (acc_k % NR);
               check("rk_idx_acc", chk_t'(rk_idx), chk_t'(rnd));
               exp_q.push_back({in_state ^ key_mem[rnd], 4'(rnd), rnd == 0});
               acc_k++;
            end
         end
         prev_hold = out_valid && !out_ready && !clear;
         prev_out  = {out_state, out_round, out_last};
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      check({tag, "_drain_q"}, chk_t'(exp_q.size()), chk_t'(0));
      check({tag, "_drain_ov"}, chk_t'(out_valid), chk_t'(0));
   endtask

   task automatic fill_two();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_state = rand128();
         tick();
      end
   endtask

   // Watchdog.
   initial begin
      #1000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int           accepts;
      logic [127:0] first;
      logic         goal;

      reset     = 1'b1;
      clear     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_state  = '0;
      for (int i = 0; i < 16; i++) key_mem[i] = rand128();
      key_mem[0] = 128'h2b7e151628aed2a6abf7158809cf4f3c;

      // Reset values while reset is held.
      repeat (3) tick();
      check("rst_out_valid", chk_t'(out_valid), chk_t'(0));
      check("rst_in_ready",  chk_t'(in_ready),  chk_t'(0));
      check("rst_out_state", chk_t'(out_state), chk_t'(0));
      check("rst_out_round", chk_t'(out_round), chk_t'(0));
      check("rst_out_last",  chk_t'(out_last),  chk_t'(0));
      check("rst_rk_idx",    chk_t'(rk_idx),    chk_t'(9));
      @(negedge clk);
      #2 reset = 1'b0;
      tick();
      check("rel_in_ready", chk_t'(in_ready), chk_t'(1));

      // 1: FIPS-197 round-0 key after 9 dummy accepts.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 9; i++) begin
         in_state = rand128();
         tick();
      end
      in_state = 128'h3243f6a8885a308d313198a2e0370734;
      check("t1_rk_idx", chk_t'(rk_idx), chk_t'(0));
      tick();
      in_valid = 1'b0;
      check("t1_out_valid", chk_t'(out_valid), chk_t'(1));
      check("t1_out_state", chk_t'(out_state), chk_t'(128'h193de3bea0f4e22b9ac68d2ae9f84808));
      check("t1_out_round", chk_t'(out_round), chk_t'(0));
      check("t1_out_last",  chk_t'(out_last),  chk_t'(1));
      check("t1_wrap",      chk_t'(rk_idx),    chk_t'(9));
      drain("t1");

      // 2: ten back-to-back accepts, one output per clock.
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_state = rand128();
         check("t2_rk_idx",   chk_t'(rk_idx),   chk_t'(9 - i));
         check("t2_in_ready", chk_t'(in_ready), chk_t'(1));
         tick();
         check("t2_out_valid", chk_t'(out_valid), chk_t'(1));
         check("t2_out_last",  chk_t'(out_last),  chk_t'(i == 9));
      end
      in_valid = 1'b0;
      check("t2_wrap", chk_t'(rk_idx), chk_t'(9));
      drain("t2");

      // 3: output stalled for 5 cycles with input pressure.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      accepts   = 0;
      first     = '0;
      for (int c = 0; c < 5; c++) begin
         in_state = rand128();
         check("t3_in_ready", chk_t'(in_ready), chk_t'(c < 2));
         if (in_valid && in_ready) accepts++;
         tick();
         if (c == 0) first = out_state;
         else check("t3_stable", chk_t'(out_state), chk_t'(first));
      end
      check("t3_accepts", chk_t'(accepts), chk_t'(2));
      drain("t3");

      // 4a: clear with one entry held and an accept in the clear cycle.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_state  = rand128();
      tick();
      clear    = 1'b1;
      in_state = rand128();
      check("t4a_in_ready_pre", chk_t'(in_ready), chk_t'(1));
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      check("t4a_out_valid", chk_t'(out_valid), chk_t'(0));
      check("t4a_in_ready",  chk_t'(in_ready),  chk_t'(1));
      check("t4a_rk_idx",    chk_t'(rk_idx),    chk_t'(9));
      tick();
      check("t4a_dropped", chk_t'(out_valid), chk_t'(0));

      // 4b: clear with both entries held and in_valid high.
      fill_two();
      check("t4b_full", chk_t'(in_ready), chk_t'(0));
      clear    = 1'b1;
      in_state = rand128();
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      check("t4b_out_valid", chk_t'(out_valid), chk_t'(0));
      check("t4b_in_ready",  chk_t'(in_ready),  chk_t'(1));
      check("t4b_rk_idx",    chk_t'(rk_idx),    chk_t'(9));
      tick();
      check("t4b_dropped", chk_t'(out_valid), chk_t'(0));

      // 5: asynchronous reset mid-clock with both entries full.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_state  = rand128();
      tick();
      fill_two();
      in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("t5_out_valid", chk_t'(out_valid), chk_t'(0));
      check("t5_out_state", chk_t'(out_state), chk_t'(0));
      check("t5_out_round", chk_t'(out_round), chk_t'(0));
      check("t5_out_last",  chk_t'(out_last),  chk_t'(0));
      check("t5_in_ready",  chk_t'(in_ready),  chk_t'(0));
      check("t5_rk_idx",    chk_t'(rk_idx),    chk_t'(9));
      @(negedge clk);
      #2 reset = 1'b0;
      tick();
      check("t5_rel_in_ready",  chk_t'(in_ready),  chk_t'(1));
      check("t5_rel_out_valid", chk_t'(out_valid), chk_t'(0));
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_state = rand128();
         tick();
      end
      drain("t5");

      // 6: random valid/ready stalls over 1000 accepted states.
      accepts = 0;
      for (int c = 0; c < 20000 && accepts < 1000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_state  = rand128();
         if (in_valid && in_ready) accepts++;
         tick();
      end
      goal = (accepts >= 1000);
      check("t6_accepts", chk_t'(goal), chk_t'(1));
      drain("t6");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
